jtdd_rom_arb: RTL
=================

# jtdd_rom_arb

Parametrised SDRAM read arbiter for game ROM slots, generalising the fixed nine-slot ROM bridge used by the game tops. It takes N independent read requests (CPU, sound, MCU, ADPCM, tile and object fetchers) and serialises them onto the single SDRAM read port. Each slot keeps a one-line 32-bit cache, so sequential reads within a line are served without SDRAM traffic. The block adds a selectable fixed-priority or round-robin grant policy and per-slot 8/16-bit data width.

## Interface
- SLOTS, 8: number of request slots (1–16).
- AW, 22: SDRAM word address width.
- SAW, 18: slot address width; all slots use the same width, and narrower users zero-pad the MSBs.
- OFFSETS, 0: packed SLOTS*AW SDRAM word offsets; slot i uses bits [i*AW +: AW].
- DW8, 0: SLOTS-bit mask; bit i=1 makes slot i byte-addressed (8-bit), bit i=0 makes it halfword-addressed (16-bit).
- RR, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- clk  in  1  system clock; one clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- downloading  in  1  ROM load in progress; blocks all requests and flushes the caches.
- slot_cs  in  SLOTS  per-slot read request, level sensitive.
- slot_addr  in  SLOTS*SAW  packed per-slot addresses.
- slot_ok  out  SLOTS  data valid for the current slot_addr.
- slot_dout  out  SLOTS*16  packed data; 8-bit slots drive [7:0], with [15:8]=0.
- sdram_req  out  1  read request.
- sdram_addr  out  AW  word address, bit0 always 0 (32-bit aligned).
- sdram_ack  in  1  request accepted.
- data_rdy  in  1  data_read valid for one cycle.
- data_read  in  32  read data; the low halfword is at the even address.
- refresh_en  out  1  high when the FSM is in IDLE and no slot misses.

## Operation
- Per-slot cache: valid bit, tag and 32-bit line.
  - 8-bit slot: tag = addr[SAW-1:2]; addr[1:0] selects the byte (0 = data_read[7:0]); SDRAM address = OFFSET + {addr[SAW-1:2],1'b0}.
  - 16-bit slot: tag = addr[SAW-1:1]; addr[0] selects the halfword; SDRAM address = OFFSET + {addr[SAW-1:1],1'b0}.
  - Address sums wrap modulo 2^AW.
- Hit = valid & tag match. slot_ok[i] = slot_cs[i] & hit[i]. slot_ok and slot_dout are combinational from the registered cache state.
- Miss = slot_cs & !hit & !downloading.
- FSM states:
  - IDLE: if any slot misses, grant one slot, latch the slot index, tag and SDRAM address, drive sdram_req=1, and go to WAIT_ACK.
  - WAIT_ACK: hold sdram_req and sdram_addr stable; on sdram_ack, drop sdram_req and go to WAIT_DATA.
  - WAIT_DATA: on data_rdy, write data_read and the latched tag into the granted slot's cache, set valid, and go to IDLE.
- Arbitration:
  - RR=0: lowest missing index wins.
  - RR=1: the search starts at (last_grant+1) mod SLOTS. last_grant updates at each grant and resets to SLOTS-1, so slot 0 is first.
- The fill always completes for the latched tag, even if slot_cs drops or slot_addr changes mid-fetch. slot_ok then reflects the current address only.
- data_rdy in IDLE or WAIT_ACK is ignored. sdram_ack in IDLE or WAIT_DATA is ignored.
- downloading=1: all valid bits are cleared every cycle, slot_ok=0, FSM forced to IDLE, sdram_req=0.
- Reset values: FSM=IDLE, sdram_req=0, sdram_addr=0, all valid=0 so slot_ok=0, slot_dout=0, refresh_en=1, last_grant=SLOTS-1. A reset mid-transaction abandons the fetch, and the late data_rdy is ignored.

## Timing
- Hit: slot_ok is high in the same cycle slot_cs/slot_addr present a cached line (0 latency).
- Miss with the FSM in IDLE at cycle 0: sdram_req=1 from cycle 1.
  - Ack sampled at cycle a ≥ 1: req=0 from a+1.
  - data_rdy sampled at cycle d > a: cache written at the end of d, slot_ok=1 in d+1.
  - Minimum miss-to-ok is 3 cycles.
- A miss arriving while the FSM is busy waits; it is granted in the first IDLE cycle after the current fill.
- Back-to-back: a slot granted in IDLE at cycle n+1 follows data_rdy at cycle n (one IDLE cycle between fills).
- refresh_en is low from the cycle any miss is seen until return to IDLE with no misses.

## Test plan
- Reset and ack timing: assert rst for 3 cycles mid-WAIT_DATA, then release with slot_cs=0 → sdram_req=0, refresh_en=1, slot_ok=0. A stale data_rdy afterwards writes nothing. Then request slot 0 with ack at the first req cycle and data_rdy the next → slot_ok[0] rises exactly 3 cycles after slot_cs.
- 8-bit slot: slot 2, DW8[2]=1, OFFSET=22'h2_8000, addr=18'h00005, data_read=32'hDDCCBBAA.
  - sdram_addr = 22'h2_8002; slot_dout = 16'h00BB.
  - Addr 6 then hits immediately with 16'h00CC and no new sdram_req.
  - Addr 8 misses with sdram_addr = 22'h2_8004.
- 16-bit slot: slot 1, OFFSET=22'h6_0000, addr=18'h00003, data_read=32'h12345678 → sdram_addr = 22'h6_0002, slot_dout = 16'h1234.
- Arbitration: slots 0, 3 and 5 miss simultaneously.
  - RR=0: grant order is 0, 3, 5.
  - RR=1 with last_grant=3: grant order is 5, 0, 3.
  - Re-asserting slot 0 constantly under RR=1 must not starve slot 5.
- Mid-fetch change: slot 4 changes address after ack → the original line fills with valid=1 and slot_ok stays 0, then a second request is issued for the new line.
- Download: with valid lines cached, pulse downloading for 1 cycle → all slot_ok fall and the next reads miss. A pending sdram_req drops immediately.

Source files
------------

// File: rtl/jtdd_rom_arb_if.sv
// Bus bundle between the ROM slot users, the arbiter and the SDRAM read port.
// The slave modport is the arbiter's view; the master modport drives the slots
// and plays the SDRAM side.
interface jtdd_rom_arb_if #(
  parameter int SLOTS = 8,
  parameter int AW    = 22,
  parameter int SAW   = 18
);
  logic [SLOTS-1:0]     slot_cs;
  logic [SLOTS*SAW-1:0] slot_addr;
  logic [SLOTS-1:0]     slot_ok;
  logic [SLOTS*16-1:0]  slot_dout;
  logic                 sdram_req;
  logic [AW-1:0]        sdram_addr;
  logic                 sdram_ack;
  logic                 data_rdy;
  logic [31:0]          data_read;

  modport slave (
    input  slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, sdram_req, sdram_addr
  );

  modport master (
    output slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtdd_rom_arb.sv
// SDRAM read arbiter for ROM slots. Each slot owns a one-line 32-bit cache;
// misses are serialised onto the single SDRAM read port with either fixed
// priority (lowest index) or round-robin granting.
module jtdd_rom_arb #(
  parameter int                  SLOTS   = 8,
  parameter int                  AW      = 22,
  parameter int                  SAW     = 18,
  parameter logic [SLOTS*AW-1:0] OFFSETS = '0,
  parameter logic [SLOTS-1:0]    DW8     = '0,
  parameter bit                  RR      = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 downloading_i,
  jtdd_rom_arb_if.slave        bus,
  output logic                 refresh_en_o
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SLOTS-1:0] valid_q;
  logic [SAW-1:0]   tag_q  [SLOTS];
  logic [31:0]      line_q [SLOTS];
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [SAW-1:0]   gtag_q, gtag_d;
  logic             req_q, req_d;
  logic [AW-1:0]    addr_q, addr_d;

  logic [SAW-1:0]   tag_s   [SLOTS];
  logic [AW-1:0]    raddr_s [SLOTS];
  logic [SLOTS-1:0] hit_s;
  logic [SLOTS-1:0] miss_s;
  logic             sel_found_s;
  logic [IW-1:0]    sel_s;
  logic [IW-1:0]    idx_s;
  int               idx_i;
  logic             fill_s;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [SAW-1:0] a_s;
    logic [15:0]    dout_s;

    assign a_s        = bus.slot_addr[i*SAW +: SAW];
    // Byte slots keep one tag per 4 bytes, halfword slots one per 2 halfwords.
    assign tag_s[i]   = DW8[i] ? {2'b00, a_s[SAW-1:2]} : {1'b0, a_s[SAW-1:1]};
    assign raddr_s[i] = OFFSETS[i*AW +: AW] + AW'({tag_s[i], 1'b0});
    assign hit_s[i]   = valid_q[i] && (tag_q[i] == tag_s[i]);
    assign miss_s[i]  = bus.slot_cs[i] && !hit_s[i] && !downloading_i;
    assign bus.slot_ok[i] = bus.slot_cs[i] && hit_s[i] && !downloading_i;
    assign bus.slot_dout[i*16 +: 16] = dout_s;

    // Select the byte or halfword of the cached line addressed by the slot.
    always_comb begin
      dout_s = 16'h0000;
      if (DW8[i]) begin
        case (a_s[1:0])
          2'd0:    dout_s = {8'h00, line_q[i][7:0]};
          2'd1:    dout_s = {8'h00, line_q[i][15:8]};
          2'd2:    dout_s = {8'h00, line_q[i][23:16]};
          2'd3:    dout_s = {8'h00, line_q[i][31:24]};
          default: dout_s = 16'h0000;
        endcase
      end else begin
        dout_s = a_s[0] ? line_q[i][31:16] : line_q[i][15:0];
      end
    end
  end

  // Pick the missing slot to serve: from slot 0, or from the one after the last grant.
  always_comb begin
    sel_found_s = 1'b0;
    sel_s       = '0;
    idx_i       = 0;
    idx_s       = '0;
    for (int k = 0; k < SLOTS; k++) begin
      idx_i = RR ? ((int'(last_q) + 1 + k) % SLOTS) : k;
      idx_s = IW'(idx_i);
      if (!sel_found_s && miss_s[idx_s]) begin
        sel_found_s = 1'b1;
        sel_s       = idx_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a download always parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    if (downloading_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = sel_found_s   ? WAIT_ACK : IDLE;
        WAIT_ACK:  state_d = bus.sdram_ack ? WAIT_DATA : WAIT_ACK;
        WAIT_DATA: state_d = bus.data_rdy  ? IDLE : WAIT_DATA;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: request/grant latching on entry and the cache fill strobe.
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    gnt_d  = gnt_q;
    gtag_d = gtag_q;
    last_d = last_q;
    fill_s = 1'b0;
    if (downloading_i) begin
      req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found_s) begin
            req_d  = 1'b1;
            addr_d = raddr_s[sel_s];
            gnt_d  = sel_s;
            gtag_d = tag_s[sel_s];
            last_d = sel_s;
          end else begin
            req_d  = 1'b0;
          end
        end
        WAIT_ACK:  req_d  = !bus.sdram_ack;
        WAIT_DATA: fill_s = bus.data_rdy;
        default:   req_d  = 1'b0;
      endcase
    end
  end

  // Request/grant registers; last grant starts at the top so slot 0 goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      gnt_q  <= '0;
      gtag_q <= '0;
      last_q <= IW'(SLOTS - 1);
    end else begin
      req_q  <= req_d;
      addr_q <= addr_d;
      gnt_q  <= gnt_d;
      gtag_q <= gtag_d;
      last_q <= last_d;
    end
  end

  // Cache lines: filled with the latched tag, flushed while downloading.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= 32'h0000_0000;
      end
    end else if (downloading_i) begin
      valid_q <= '0;
    end else if (fill_s) begin
      valid_q[gnt_q] <= 1'b1;
      tag_q[gnt_q]   <= gtag_q;
      line_q[gnt_q]  <= bus.data_read;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign bus.sdram_req  = req_q && !downloading_i;
  assign bus.sdram_addr = addr_q;
  assign refresh_en_o   = (state_q == IDLE) && !(|miss_s);

endmodule
